// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared Q-table widths, FSM encoding and address helper
package tictactoe_pkg;

    localparam int STATE_W = 14;
    localparam int Q_W     = 18;
    localparam int ACT_W   = 4;
    localparam int N_ACT   = 9;
    localparam int ADDR_W  = STATE_W + ACT_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CUR  = 3'd1,
        ST_RD_NXT  = 3'd2,
        ST_RD_LAST = 3'd3,
        ST_CALC    = 3'd4,
        ST_WR      = 3'd5
    } upd_state_e;

    // Q-table word address: state in the upper bits, action in the low nibble.
    function automatic logic [ADDR_W-1:0] q_addr(input logic [STATE_W-1:0] s,
                                                 input logic [ACT_W-1:0]   a);
        return {s, a};
    endfunction

endpackage

// File: rtl/q_arith_sat.sv
// rtl/q_arith_sat.sv - combinational Q-learning update with saturation to [0, 2^Q_W-1]
module q_arith_sat #(
    parameter int Q_W         = 18,
    parameter int R_W         = 8,
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic [Q_W-1:0] q_cur_i,
    input  logic [Q_W-1:0] q_max_i,
    input  logic [R_W-1:0] reward_i,
    output logic [Q_W-1:0] q_new_o
);

    localparam int AW = Q_W + 3;

    logic signed [AW-1:0] m_s, q_s, r_s, g_s, t_s, d_s, n_s;

    always_comb begin
        m_s = {3'b000, q_max_i};
        q_s = {3'b000, q_cur_i};
        r_s = {{(AW-R_W){reward_i[R_W-1]}}, reward_i};
        g_s = m_s - (m_s >>> GAMMA_SHIFT);
        t_s = r_s + g_s;
        d_s = t_s - q_s;
        n_s = q_s + (d_s >>> ALPHA_SHIFT);
        // Three guard bits: sign says underflow, any other guard bit says overflow.
        if (n_s[AW-1]) begin
            q_new_o = '0;
        end else if (|n_s[AW-2:Q_W]) begin
            q_new_o = '1;
        end else begin
            q_new_o = n_s[Q_W-1:0];
        end
    end

endmodule

// File: rtl/q_value_updater.sv
// rtl/q_value_updater.sv - sequences Q(s,a) and Q(s',0..8) reads, computes and writes back one Q update
module q_value_updater
    import tictactoe_pkg::*;
#(
    parameter int STATE_W     = tictactoe_pkg::STATE_W,
    parameter int Q_W         = tictactoe_pkg::Q_W,
    parameter int R_W         = 8,
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [STATE_W-1:0]   cur_state,
    input  logic [3:0]           action,
    input  logic [R_W-1:0]       reward,
    input  logic [STATE_W-1:0]   next_state,
    input  logic                 terminal,
    output logic [STATE_W+3:0]   mem_rd_addr,
    input  logic [Q_W-1:0]       mem_rd_data,
    output logic                 mem_wr_en,
    output logic [STATE_W+3:0]   mem_wr_addr,
    output logic [Q_W-1:0]       mem_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [ACT_W-1:0] K_LAST = ACT_W'(N_ACT - 1);

    upd_state_e           state_q;
    logic [ACT_W-1:0]     k_q;
    logic [STATE_W-1:0]   cur_q, nxt_q;
    logic [ACT_W-1:0]     act_q;
    logic [R_W-1:0]       reward_q;
    logic                 term_q, inval_q;
    logic [Q_W-1:0]       qsa_q, max_q, max_eff;
    logic [STATE_W+3:0]   rd_addr_q, wr_addr_q;
    logic [Q_W-1:0]       wr_data_q, wr_data_d;
    logic                 wr_en_q, busy_q, done_q, err_q;

    assign max_eff = term_q ? '0 : max_q;

    q_arith_sat #(
        .Q_W         (Q_W),
        .R_W         (R_W),
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .GAMMA_SHIFT (GAMMA_SHIFT)
    ) u_arith (
        .q_cur_i  (qsa_q),
        .q_max_i  (max_eff),
        .reward_i (reward_q),
        .q_new_o  (wr_data_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            cur_q     <= '0;
            nxt_q     <= '0;
            act_q     <= '0;
            reward_q  <= '0;
            term_q    <= 1'b0;
            inval_q   <= 1'b0;
            qsa_q     <= '0;
            max_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_q     <= cur_state;
                        nxt_q     <= next_state;
                        act_q     <= action;
                        reward_q  <= reward;
                        term_q    <= terminal;
                        inval_q   <= (action > K_LAST);
                        rd_addr_q <= q_addr(cur_state, action);
                        busy_q    <= 1'b1;
                        state_q   <= ST_RD_CUR;
                    end
                end
                ST_RD_CUR: begin
                    k_q       <= '0;
                    rd_addr_q <= q_addr(nxt_q, '0);
                    state_q   <= ST_RD_NXT;
                end
                ST_RD_NXT: begin
                    // Read data lags the address by one cycle: k=0 returns Q(s,a).
                    if (k_q == '0) begin
                        qsa_q <= mem_rd_data;
                        max_q <= '0;
                    end else if (mem_rd_data > max_q) begin
                        max_q <= mem_rd_data;
                    end
                    if (k_q == K_LAST) begin
                        state_q <= ST_RD_LAST;
                    end else begin
                        k_q       <= k_q + ACT_W'(1);
                        rd_addr_q <= q_addr(nxt_q, k_q + ACT_W'(1));
                    end
                end
                ST_RD_LAST: begin
                    if (mem_rd_data > max_q) begin
                        max_q <= mem_rd_data;
                    end
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    wr_data_q <= wr_data_d;
                    wr_addr_q <= q_addr(cur_q, act_q);
                    wr_en_q   <= ~inval_q;
                    done_q    <= 1'b1;
                    err_q     <= inval_q;
                    state_q   <= ST_WR;
                end
                ST_WR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
